wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file in core_v1.
- Merges two result sources into the single regfile write port (rd_addr / w_data / w_en):
  - single-cycle ALU results;
  - variable-latency load results, delivered through a valid/ready handshake and buffered in a small FIFO.
- Keeps a per-register pending-load scoreboard and reports a RAW hazard to decode for the two source operands being read.

---
 rtl/wb_arbiter.sv | 106 ++++++++++
 tb/tb_wb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load results into the
// single register-file write port and tracks pending loads for decode.
module wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int LQ_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               alu_valid,
    input  logic [RADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]    alu_data,
    input  logic               ld_issue,
    input  logic [RADDR_W-1:0] ld_issue_rd,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [RADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]    ld_data,
    input  logic [RADDR_W-1:0] rs1_addr,
    input  logic [RADDR_W-1:0] rs2_addr,
    output logic               hazard,
    output logic [RADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]    w_data,
    output logic               w_en
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = $clog2(LQ_DEPTH + 1);
    localparam int NREG  = 1 << RADDR_W;

    logic [RADDR_W-1:0] lq_rd   [LQ_DEPTH];
    logic [XLEN-1:0]    lq_data [LQ_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic               pushed_q;
    logic [NREG-1:0]    busy;
    logic [NREG-1:0]    busy_next;
    logic               push;
    logic               pop;

    assign ld_ready = (count < CNT_W'(LQ_DEPTH));
    assign push     = ld_valid && ld_ready;

    // An entry pushed on the last edge is not yet eligible, giving the
    // two-cycle minimum load latency without any bypass path.
    assign pop = !alu_valid && (count > CNT_W'(pushed_q));

    assign hazard = ((rs1_addr != '0) && busy[rs1_addr])
                 || ((rs2_addr != '0) && busy[rs2_addr]);

    always_comb begin
        busy_next = busy;
        if (pop)
            busy_next[lq_rd[head]] = 1'b0;
        if (ld_issue && (ld_issue_rd != '0))
            busy_next[ld_issue_rd] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            lq_rd[tail]   <= ld_rd;
            lq_data[tail] <= ld_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pushed_q <= 1'b0;
            busy     <= '0;
            rd_addr  <= '0;
            w_data   <= '0;
            w_en     <= 1'b0;
        end else begin
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            count    <= count + CNT_W'(push) - CNT_W'(pop);
            pushed_q <= push;
            busy     <= busy_next;
            if (alu_valid) begin
                rd_addr <= alu_rd;
                w_data  <= alu_data;
                w_en    <= (alu_rd != '0);
            end else if (pop) begin
                rd_addr <= lq_rd[head];
                w_data  <= lq_data[head];
                w_en    <= (lq_rd[head] != '0);
            end else begin
                w_en <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    a_alu_busy: assert property (@(posedge clock) disable iff (reset)
        alu_valid |-> (alu_rd == '0 || !busy[alu_rd]));
    a_ld_idle: assert property (@(posedge clock) disable iff (reset)
        (push && ld_rd != '0) |-> busy[ld_rd]);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed stimulus with an in-order queue of
// expected register-file writes checked by a monitor.
module tb_wb_arbiter;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    logic               clock;
    logic               reset;
    logic               alu_valid;
    logic [RADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]    alu_data;
    logic               ld_issue;
    logic [RADDR_W-1:0] ld_issue_rd;
    logic               ld_valid;
    logic               ld_ready;
    logic [RADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]    ld_data;
    logic [RADDR_W-1:0] rs1_addr;
    logic [RADDR_W-1:0] rs2_addr;
    logic               hazard;
    logic [RADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]    w_data;
    logic               w_en;

    int total = 0;
    int bad   = 0;

    logic [RADDR_W+XLEN-1:0] exp_q[$];

    wb_arbiter #(.XLEN(XLEN), .RADDR_W(RADDR_W), .LQ_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_rd(ld_rd), .ld_data(ld_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard),
        .rd_addr(rd_addr), .w_data(w_data), .w_en(w_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Every enabled write must match the next expected write, in order.
    always @(negedge clock) begin
        if (!reset && w_en) begin
            if (exp_q.size() == 0)
                chk("unexp_wr", 64'(exp_q.size()), 64'd1);
            else
                chk("wr", {rd_addr, w_data}, exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        rs1_addr = 5'd5; rs2_addr = '0;
        tick();
        tick();
        chk("rst_wen", w_en, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_data", w_data, 0);
        chk("rst_rdy", ld_ready, 1);
        chk("rst_haz", hazard, 0);
        rs1_addr = '0;
        reset = 1'b0;
        tick();

        // ALU path, x0 write, idle hold
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        exp_q.push_back({5'd3, 32'hDEADBEEF});
        tick();
        chk("alu_wen", w_en, 1);
        chk("alu_addr", rd_addr, 3);
        chk("alu_data", w_data, 64'hDEADBEEF);
        alu_rd = 5'd0; alu_data = 32'h55;
        tick();
        chk("x0_wen", w_en, 0);
        chk("x0_addr", rd_addr, 0);
        alu_valid = 1'b0;
        tick();
        chk("idle_wen", w_en, 0);
        chk("idle_hold", w_data, 64'h55);

        // Load path latency and hazard release
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        tick();
        ld_issue = 1'b0; rs1_addr = 5'd7;
        #1;
        chk("ld_haz", hazard, 1);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
        exp_q.push_back({5'd7, 32'h1234});
        chk("ld_rdy", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        chk("ld_n_wen", w_en, 0);
        tick();
        chk("ld_n1_wen", w_en, 0);
        chk("ld_n1_haz", hazard, 1);
        tick();
        chk("ld_n2_wen", w_en, 1);
        chk("ld_n2_addr", rd_addr, 7);
        chk("ld_n2_haz", hazard, 0);
        rs1_addr = '0;

        // Contention: ALU starves loads; buffer fills to two
        ld_issue = 1'b1;
        ld_issue_rd = 5'd8;  tick();
        ld_issue_rd = 5'd9;  tick();
        ld_issue_rd = 5'd13; tick();
        ld_issue = 1'b0;
        for (int i = 0; i < 3; i++)
            exp_q.push_back({5'(10 + i), 32'(32'hA000 + i)});
        exp_q.push_back({5'd8, 32'hB000});
        exp_q.push_back({5'd9, 32'hB001});
        exp_q.push_back({5'd13, 32'hB00D});
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1;
            alu_rd = 5'(10 + i);
            alu_data = 32'(32'hA000 + i);
            ld_valid = (i < 2);
            ld_rd = 5'(8 + i);
            ld_data = 32'(32'hB000 + i);
            #1;
            chk("cont_rdy", ld_ready, 64'(i < 2));
            tick();
        end

        // Full boundary: pop with a load offered while full
        alu_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd13; ld_data = 32'hB00D;
        #1;
        chk("full_rdy", ld_ready, 0);
        tick();
        chk("pop_rdy", ld_ready, 1);
        chk("pop_addr", rd_addr, 8);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("post_rdy", ld_ready, 1);
        chk("x9_addr", rd_addr, 9);
        tick();
        chk("x13_gap", w_en, 0);
        tick();
        chk("x13_wen", w_en, 1);

        // Set/clear collision on x4
        ld_issue = 1'b1; ld_issue_rd = 5'd4;
        tick();
        ld_issue = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h4444;
        exp_q.push_back({5'd4, 32'h4444});
        tick();
        ld_valid = 1'b0;
        tick();
        ld_issue = 1'b1; ld_issue_rd = 5'd4; rs2_addr = 5'd4;
        tick();
        ld_issue = 1'b0;
        #1;
        chk("col_wen", w_en, 1);
        chk("col_haz", hazard, 1);
        tick();
        chk("col_hold", hazard, 1);
        rs2_addr = '0;

        // Reset mid-operation with two loads buffered
        ld_issue = 1'b1;
        ld_issue_rd = 5'd5; tick();
        ld_issue_rd = 5'd6; tick();
        ld_issue = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd0;
        ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'h5555;
        tick();
        ld_rd = 5'd6; ld_data = 32'h6666;
        tick();
        ld_valid = 1'b0;
        alu_rd = 5'd21; alu_data = 32'h2121;
        tick();
        rs1_addr = 5'd5;
        #1;
        chk("pre_rdy", ld_ready, 0);
        chk("pre_haz", hazard, 1);
        chk("pre_wen", w_en, 1);
        reset = 1'b1;
        #1;
        chk("mid_wen", w_en, 0);
        chk("mid_rdy", ld_ready, 1);
        chk("mid_haz", hazard, 0);
        alu_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rel_rdy", ld_ready, 1);
        chk("rel_haz", hazard, 0);
        tick();
        tick();
        tick();
        chk("rel_wen", w_en, 0);
        chk("q_empty", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
